// File: rtl/bitstream_self_loader_if.sv
// Byte stream handshake between a bitstream source (host or UART) and the loader.
interface bitstream_self_loader_if;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;

  // Source side: presents bytes, observes ready.
  modport master (
    output byte_data,
    output byte_valid,
    input  byte_ready
  );

  // Loader side: consumes bytes, drives ready.
  modport slave (
    input  byte_data,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/bitstream_self_loader.sv
// Packs an incoming byte stream into big-endian 32-bit words and writes each word to the
// fabric configuration port with a setup period, a one-cycle strobe and an idle gap.
module bitstream_self_loader #(
  parameter int unsigned MAX_BITBYTES = 20000,
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic                          CLK,
  input  logic                          reset,
  bitstream_self_loader_if.slave        byte_if,
  output logic [31:0]                   SelfWriteData,
  output logic                          SelfWriteStrobe,
  output logic [15:0]                   words_written,
  output logic                          busy,
  output logic                          done
);

  localparam logic [15:0] WordsTotal = 16'(MAX_BITBYTES / 4);
  localparam logic [15:0] SetupLast  = 16'(SETUP_CYCLES - 1);
  // Only meaningful when the gap is enabled.
  localparam logic [15:0] GapLast    = 16'(GAP_CYCLES - 1);
  localparam bit          GapEn      = (GAP_CYCLES != 0);

  typedef enum logic [2:0] {
    StCollect,
    StSetup,
    StStrobe,
    StGap,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] data_q, data_d;
  logic        strobe_q, strobe_d;
  logic [15:0] words_q, words_d;
  logic [15:0] wait_q, wait_d;
  logic        accept;
  logic [15:0] words_inc;

  // Ready depends only on state; reset forces it low within the same cycle.
  assign byte_if.byte_ready = (state_q == StCollect) && !reset;
  assign accept             = byte_if.byte_valid && byte_if.byte_ready;
  assign words_inc          = (words_q == 16'hFFFF) ? words_q : words_q + 16'd1;

  assign SelfWriteData   = data_q;
  assign SelfWriteStrobe = strobe_q;
  assign words_written   = words_q;
  assign done            = (state_q == StDone);
  assign busy            = !((state_q == StCollect) && (byte_cnt_q == 2'd0)) &&
                           (state_q != StDone);

  // Next-state logic: byte packing, setup/gap timing and completion decision.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    strobe_d   = 1'b0;
    words_d    = words_q;
    wait_d     = wait_q;
    unique case (state_q)
      StCollect: begin
        if (accept) begin
          if (byte_cnt_q == 2'd3) begin
            data_d     = {shift_q, byte_if.byte_data};
            byte_cnt_d = 2'd0;
            wait_d     = 16'd0;
            state_d    = StSetup;
          end else begin
            shift_d    = {shift_q[15:0], byte_if.byte_data};
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end
      StSetup: begin
        if (wait_q == SetupLast) begin
          wait_d   = 16'd0;
          strobe_d = 1'b1;
          state_d  = StStrobe;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      StStrobe: begin
        words_d = words_inc;
        wait_d  = 16'd0;
        if (GapEn) begin
          state_d = StGap;
        end else begin
          state_d = (words_inc == WordsTotal) ? StDone : StCollect;
        end
      end
      StGap: begin
        if (wait_q == GapLast) begin
          state_d = (words_q == WordsTotal) ? StDone : StCollect;
        end else begin
          wait_d = wait_q + 16'd1;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StCollect;
      end
    endcase
  end

  // State register; reset aborts any word in flight, including a pending strobe.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= StCollect;
      byte_cnt_q <= 2'd0;
      shift_q    <= 24'h0;
      data_q     <= 32'h0;
      strobe_q   <= 1'b0;
      words_q    <= 16'h0;
      wait_q     <= 16'h0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      strobe_q   <= strobe_d;
      words_q    <= words_d;
      wait_q     <= wait_d;
    end
  end

endmodule

// File: tb/tb_bitstream_self_loader.sv
// Randomised bench for bitstream_self_loader: three instances cover the default timing,
// a two-word completion case and the zero-gap fast case against a timing-rule model.
module tb_bitstream_self_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst [3];
  logic [7:0]  d   [3];
  logic        v   [3];
  logic        rdy [3];
  logic [31:0] swd [3];
  logic        stb [3];
  logic [15:0] ww  [3];
  logic        bsy [3];
  logic        dn  [3];

  bitstream_self_loader_if if0 ();
  bitstream_self_loader_if if1 ();
  bitstream_self_loader_if if2 ();

  assign if0.byte_data = d[0];
  assign if0.byte_valid = v[0];
  assign rdy[0] = if0.byte_ready;
  assign if1.byte_data = d[1];
  assign if1.byte_valid = v[1];
  assign rdy[1] = if1.byte_ready;
  assign if2.byte_data = d[2];
  assign if2.byte_valid = v[2];
  assign rdy[2] = if2.byte_ready;

  bitstream_self_loader #(.MAX_BITBYTES(20000), .SETUP_CYCLES(2), .GAP_CYCLES(2)) u0 (
    .CLK(clk), .reset(rst[0]), .byte_if(if0), .SelfWriteData(swd[0]),
    .SelfWriteStrobe(stb[0]), .words_written(ww[0]), .busy(bsy[0]), .done(dn[0])
  );
  bitstream_self_loader #(.MAX_BITBYTES(8), .SETUP_CYCLES(2), .GAP_CYCLES(2)) u1 (
    .CLK(clk), .reset(rst[1]), .byte_if(if1), .SelfWriteData(swd[1]),
    .SelfWriteStrobe(stb[1]), .words_written(ww[1]), .busy(bsy[1]), .done(dn[1])
  );
  bitstream_self_loader #(.MAX_BITBYTES(20000), .SETUP_CYCLES(1), .GAP_CYCLES(0)) u2 (
    .CLK(clk), .reset(rst[2]), .byte_if(if2), .SelfWriteData(swd[2]),
    .SelfWriteStrobe(stb[2]), .words_written(ww[2]), .busy(bsy[2]), .done(dn[2])
  );

  // Per-instance configuration and model state.
  int S   [3] = '{2, 2, 1};
  int G   [3] = '{2, 2, 0};
  int TOT [3] = '{5000, 2, 5000};
  int          n_words [3];
  int          pcnt    [3];
  int          last_k  [3];
  int          strobes [3];
  int          acc     [3];
  logic [31:0] part      [3];
  logic [31:0] last_word [3];

  int checks = 0;
  int errors = 0;
  int strobe_log[$];

  // One clock of stimulus on instance i, with every output compared to the timing model:
  // a word completed at edge k strobes in cycle k+S, counts from k+S+1, and ready returns
  // at k+S+G+1.
  task automatic cycle(input int i, input logic vin, input logic [7:0] din, output logic took);
    int c;
    logic in_win, done_e, strobe_e, ready_e, busy_e;
    logic [15:0] ww_e;
    v[i] = vin;
    d[i] = din;
    @(negedge clk);
    c = cyc;
    in_win   = (n_words[i] > 0) && (c >= last_k[i]) && (c <= last_k[i] + S[i] + G[i]);
    done_e   = (n_words[i] == TOT[i]) && (c > last_k[i] + S[i] + G[i]);
    strobe_e = (n_words[i] > 0) && (c == last_k[i] + S[i]);
    ready_e  = !in_win && !done_e;
    busy_e   = in_win || (!done_e && pcnt[i] != 0);
    ww_e     = 16'(n_words[i] - (((n_words[i] > 0) && (c <= last_k[i] + S[i])) ? 1 : 0));
    checks++;
    if (rdy[i] !== ready_e) begin
      errors++;
      $display("FAIL ready inst%0d cyc%0d got %b want %b", i, c, rdy[i], ready_e);
    end
    checks++;
    if (stb[i] !== strobe_e) begin
      errors++;
      $display("FAIL strobe inst%0d cyc%0d got %b want %b", i, c, stb[i], strobe_e);
    end
    checks++;
    if (swd[i] !== last_word[i]) begin
      errors++;
      $display("FAIL data inst%0d cyc%0d got %h want %h", i, c, swd[i], last_word[i]);
    end
    checks++;
    if (ww[i] !== ww_e) begin
      errors++;
      $display("FAIL words inst%0d cyc%0d got %0d want %0d", i, c, ww[i], ww_e);
    end
    checks++;
    if (bsy[i] !== busy_e) begin
      errors++;
      $display("FAIL busy inst%0d cyc%0d got %b want %b", i, c, bsy[i], busy_e);
    end
    checks++;
    if (dn[i] !== done_e) begin
      errors++;
      $display("FAIL done inst%0d cyc%0d got %b want %b", i, c, dn[i], done_e);
    end
    if (stb[i] === 1'b1) begin
      strobes[i]++;
      strobe_log.push_back(c);
    end
    took = vin && ready_e;
    if (took) begin
      acc[i]++;
      part[i] = {part[i][23:0], din};
      pcnt[i]++;
      if (pcnt[i] == 4) begin
        last_word[i] = part[i];
        n_words[i]++;
        last_k[i] = c + 1;
        pcnt[i] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int i);
    rst[i] = 1'b1;
    v[i]   = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy[i] !== 1'b0) begin
      errors++;
      $display("FAIL ready_in_reset inst%0d got %b want 0", i, rdy[i]);
    end
    @(posedge clk);
    #1;
    rst[i]       = 1'b0;
    n_words[i]   = 0;
    pcnt[i]      = 0;
    part[i]      = 32'h0;
    last_word[i] = 32'h0;
    last_k[i]    = -1000;
    strobes[i]   = 0;
    acc[i]       = 0;
  endtask

  task automatic idle(input int i, input int n);
    logic took;
    for (int j = 0; j < n; j++) cycle(i, 1'b0, 8'h00, took);
  endtask

  // Offers bytes with valid held high until all are taken or the budget runs out.
  task automatic stream(input int i, input logic [7:0] bytes[$], input int budget,
                        output int taken, output int stalls);
    logic took;
    taken  = 0;
    stalls = 0;
    for (int n = 0; n < budget && taken < bytes.size(); n++) begin
      cycle(i, 1'b1, bytes[taken], took);
      if (took) taken++;
      else stalls++;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) do_reset(i);
    checks++;
    if (rdy[0] !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", rdy[0]); end
    checks++;
    if (swd[0] !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", swd[0]); end
    checks++;
    if (stb[0] !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b want 0", stb[0]); end
    checks++;
    if (ww[0] !== 16'h0) begin errors++; $display("FAIL reset_words got %0d want 0", ww[0]); end
    checks++;
    if (bsy[0] !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bsy[0]); end
    checks++;
    if (dn[0] !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", dn[0]); end
  endtask

  task automatic test_single_word();
    logic [7:0] b[$];
    int taken, stalls, k;
    do_reset(0);
    strobe_log.delete();
    b = '{8'h12, 8'h34, 8'h56, 8'h78};
    stream(0, b, 20, taken, stalls);
    k = cyc;
    idle(0, 10);
    checks++;
    if (strobes[0] != 1) begin errors++; $display("FAIL single_strobes got %0d want 1", strobes[0]); end
    checks++;
    if (strobe_log.size() != 1 || strobe_log[0] != k + 2) begin
      errors++;
      $display("FAIL single_strobe_time got %0d want %0d", strobe_log.size() > 0 ? strobe_log[0] : -1, k + 2);
    end
    checks++;
    if (swd[0] !== 32'h12345678) begin errors++; $display("FAIL single_data got %h want 12345678", swd[0]); end
    checks++;
    if (ww[0] !== 16'd1) begin errors++; $display("FAIL single_words got %0d want 1", ww[0]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b[$];
    int taken, stalls;
    do_reset(0);
    for (int j = 0; j < 12; j++) b.push_back(8'($urandom));
    stream(0, b, 200, taken, stalls);
    idle(0, 12);
    checks++;
    if (taken != 12) begin errors++; $display("FAIL b2b_taken got %0d want 12", taken); end
    checks++;
    if (stalls != 10) begin errors++; $display("FAIL b2b_stalls got %0d want 10", stalls); end
    checks++;
    if (strobes[0] != 3) begin errors++; $display("FAIL b2b_strobes got %0d want 3", strobes[0]); end
    checks++;
    if (swd[0] !== {b[8], b[9], b[10], b[11]}) begin
      errors++;
      $display("FAIL b2b_data got %h want %h", swd[0], {b[8], b[9], b[10], b[11]});
    end
  endtask

  task automatic test_random();
    logic took;
    do_reset(0);
    for (int j = 0; j < 400; j++) cycle(0, ($urandom_range(0, 99) < 60), 8'($urandom), took);
    idle(0, 12);
    checks++;
    if (ww[0] !== 16'(n_words[0])) begin
      errors++;
      $display("FAIL rand_words got %0d want %0d", ww[0], n_words[0]);
    end
    checks++;
    if (strobes[0] != n_words[0]) begin
      errors++;
      $display("FAIL rand_strobes got %0d want %0d", strobes[0], n_words[0]);
    end
  endtask

  task automatic test_partial_hold();
    logic [7:0] b[$];
    logic [7:0] b2[$];
    int taken, stalls;
    do_reset(0);
    b  = '{8'($urandom), 8'($urandom)};
    b2 = '{8'($urandom), 8'($urandom)};
    stream(0, b, 10, taken, stalls);
    idle(0, 30);
    checks++;
    if (strobes[0] != 0) begin errors++; $display("FAIL hold_strobes got %0d want 0", strobes[0]); end
    checks++;
    if (bsy[0] !== 1'b1) begin errors++; $display("FAIL hold_busy got %b want 1", bsy[0]); end
    stream(0, b2, 10, taken, stalls);
    idle(0, 8);
    checks++;
    if (swd[0] !== {b[0], b[1], b2[0], b2[1]}) begin
      errors++;
      $display("FAIL hold_data got %h want %h", swd[0], {b[0], b[1], b2[0], b2[1]});
    end
  endtask

  task automatic test_mid_word_reset();
    logic [7:0] b[$];
    int taken, stalls;
    do_reset(0);
    b = '{8'h11, 8'h22};
    stream(0, b, 10, taken, stalls);
    do_reset(0);
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    stream(0, b, 10, taken, stalls);
    idle(0, 10);
    checks++;
    if (swd[0] !== 32'hAABBCCDD) begin errors++; $display("FAIL midreset_data got %h want aabbccdd", swd[0]); end
    checks++;
    if (ww[0] !== 16'd1) begin errors++; $display("FAIL midreset_words got %0d want 1", ww[0]); end
    checks++;
    if (strobes[0] != 1) begin errors++; $display("FAIL midreset_strobes got %0d want 1", strobes[0]); end
  endtask

  task automatic test_reset_in_setup();
    logic [7:0] b[$];
    int taken, stalls;
    do_reset(0);
    for (int j = 0; j < 4; j++) b.push_back(8'($urandom));
    stream(0, b, 10, taken, stalls);
    do_reset(0);
    idle(0, 10);
    checks++;
    if (strobes[0] != 0) begin errors++; $display("FAIL setupreset_strobes got %0d want 0", strobes[0]); end
    checks++;
    if (swd[0] !== 32'h0) begin errors++; $display("FAIL setupreset_data got %h want 0", swd[0]); end
    checks++;
    if (ww[0] !== 16'd0) begin errors++; $display("FAIL setupreset_words got %0d want 0", ww[0]); end
  endtask

  task automatic test_completion();
    logic [7:0] b[$];
    int taken, stalls;
    do_reset(1);
    for (int j = 0; j < 12; j++) b.push_back(8'($urandom));
    stream(1, b, 40, taken, stalls);
    checks++;
    if (taken != 8) begin errors++; $display("FAIL done_taken got %0d want 8", taken); end
    checks++;
    if (strobes[1] != 2) begin errors++; $display("FAIL done_strobes got %0d want 2", strobes[1]); end
    checks++;
    if (dn[1] !== 1'b1) begin errors++; $display("FAIL done_flag got %b want 1", dn[1]); end
    checks++;
    if (swd[1] !== {b[4], b[5], b[6], b[7]}) begin
      errors++;
      $display("FAIL done_data got %h want %h", swd[1], {b[4], b[5], b[6], b[7]});
    end
    checks++;
    if (ww[1] !== 16'd2) begin errors++; $display("FAIL done_words got %0d want 2", ww[1]); end
  endtask

  task automatic test_fast();
    logic [7:0] b[$];
    int taken, stalls;
    do_reset(2);
    strobe_log.delete();
    for (int j = 0; j < 20; j++) b.push_back(8'($urandom));
    stream(2, b, 100, taken, stalls);
    idle(2, 5);
    checks++;
    if (strobe_log.size() != 5) begin
      errors++;
      $display("FAIL fast_strobes got %0d want 5", strobe_log.size());
    end
    for (int j = 1; j < strobe_log.size(); j++) begin
      checks++;
      if (strobe_log[j] - strobe_log[j-1] != 6) begin
        errors++;
        $display("FAIL fast_interval got %0d want 6", strobe_log[j] - strobe_log[j-1]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      v[i]   = 1'b0;
      d[i]   = 8'h00;
    end
    @(posedge clk);
    #1;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_random();
    test_partial_hold();
    test_mid_word_reset();
    test_reset_in_setup();
    test_completion();
    test_fast();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitstream_self_loader.md
BITSTREAM_SELF_LOADER -- requirements
Module: bitstream_self_loader

Interface
REQ-001 SHALL have parameter MAX_BITBYTES, default 20000, total bitstream bytes to load; must be a multiple of 4.
REQ-002 SHALL have parameter SETUP_CYCLES, default 2, cycles SelfWriteData is held stable before the strobe (minimum 1).
REQ-003 SHALL have parameter GAP_CYCLES, default 2, idle cycles after the strobe before the next byte is accepted (minimum 0).
REQ-004 SHALL have port CLK  input  1  sole clock; all state changes on the rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port byte_data  input  8  bitstream byte from the host or UART source.
REQ-007 SHALL have port byte_valid  input  1  byte_data is valid this cycle.
REQ-008 SHALL have port byte_ready  output  1  loader accepts byte_data this cycle.
REQ-009 SHALL have port SelfWriteData  output  32  word presented to the fabric config port.
REQ-010 SHALL have port SelfWriteStrobe  output  1  single-cycle write pulse to the fabric config port.
REQ-011 SHALL have port words_written  output  16  count of strobes issued since reset.
REQ-012 SHALL have port busy  output  1  high while any state other than COLLECT-with-zero-bytes or DONE is active.
REQ-013 SHALL have port done  output  1  high once MAX_BITBYTES/4 words have been strobed.

Function
REQ-014 SHALL implement states COLLECT, SETUP, STROBE, GAP and DONE.
REQ-015 SHALL accept a byte only on a cycle where byte_valid and byte_ready are both high.
REQ-016 SHALL drive byte_ready high only in COLLECT; it is combinational from state and not from byte_valid.
REQ-017 SHALL pack bytes big-endian: the first accepted byte of a word goes to [31:24] and the fourth to [7:0].
REQ-018 SHALL, on the edge accepting the 4th byte of a word, load the packed word into SelfWriteData, clear the byte counter and enter SETUP.
REQ-019 SHALL change SelfWriteData only on the edge accepting a 4th byte; it holds through SETUP, STROBE, GAP and COLLECT.
REQ-020 SHALL remain in SETUP for exactly SETUP_CYCLES cycles, then enter STROBE.
REQ-021 SHALL assert SelfWriteStrobe as a registered output for exactly the one cycle spent in STROBE and keep it low otherwise.
REQ-022 SHALL increment words_written on leaving STROBE; the counter saturates at 16'hFFFF.
REQ-023 SHALL remain in GAP for GAP_CYCLES cycles, or skip GAP when GAP_CYCLES is 0.
REQ-024 SHALL leave GAP (or STROBE when GAP_CYCLES is 0) to DONE if words_written equals MAX_BITBYTES/4, otherwise to COLLECT.
REQ-025 SHALL give a per-word timing of 4th byte accepted at edge k, strobe high during the cycle after edge k+SETUP_CYCLES, and byte_ready high again SETUP_CYCLES+1+GAP_CYCLES cycles after edge k.
REQ-026 SHALL, in DONE, hold done=1, byte_ready=0, SelfWriteStrobe=0 and SelfWriteData at the last word, ignoring byte_valid until reset.
REQ-027 SHALL ignore byte_valid pulses outside COLLECT without side effects; there is no buffering.
REQ-028 SHALL hold a partial word (1-3 bytes) in COLLECT indefinitely while byte_valid is low, without issuing a strobe.

Reset
REQ-029 SHALL, when reset is high at a rising edge, set state=COLLECT, byte counter=0, SelfWriteData=32'h0, SelfWriteStrobe=0, words_written=0, done=0 and busy=0.
REQ-030 SHALL drive byte_ready=0 during any cycle in which reset is high.
REQ-031 SHALL, when reset is asserted mid-word or mid-strobe sequence, discard partial bytes and suppress any pending strobe; the fabric sees no further strobe for the aborted word.

Verification
REQ-032 SHALL be covered by a single-word test: bytes 12,34,56,78 with byte_valid held high -> SelfWriteData=32'h12345678 from the edge accepting 78, strobe high exactly 1 cycle, 2 cycles later, words_written=1.
REQ-033 SHALL be covered by a back-pressure test: byte_valid held high for 3 words -> byte_ready low for exactly 5 cycles after each 4th byte, 3 strobes, no byte lost or duplicated.
REQ-034 SHALL be covered by a completion test with MAX_BITBYTES=8: 12 bytes offered -> 2 strobes, done=1, bytes 9-12 never accepted, SelfWriteData holds word 2.
REQ-035 SHALL be covered by a mid-word reset test: 2 bytes accepted, then reset for 1 cycle, then bytes AA,BB,CC,DD -> single word 32'hAABBCCDD, words_written=1.
REQ-036 SHALL be covered by a reset-during-SETUP test -> no strobe issued, SelfWriteData=0, words_written=0.
REQ-037 SHALL be covered by a GAP_CYCLES=0, SETUP_CYCLES=1 test: 4-byte words streamed continuously -> one strobe every 6 cycles.
